// File: rtl/jtkcpu_pshpul.sv
// Byte-serial push/pull sequencer: walks a register mask in stack order and
// moves each selected register one byte at a time over the 8-bit memory bus.
module jtkcpu_pshpul #(
    parameter int unsigned     NREG = 8,
    parameter logic [NREG-1:0] WIDE = 8'hF0,
    parameter int unsigned     AW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               start,
    input  logic               dir,
    input  logic [NREG-1:0]    mask,
    input  logic [AW-1:0]      sp_in,
    input  logic [NREG*16-1:0] reg_din,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_we,
    output logic               mem_rd,
    output logic [7:0]         mem_dout,
    input  logic [7:0]         mem_din,
    input  logic               mem_ok,
    output logic               wr_en,
    output logic [NREG-1:0]    wr_sel,
    output logic               wr_hi,
    output logic [7:0]         wr_data,
    output logic [AW-1:0]      sp_out,
    output logic               sp_we,
    output logic [4:0]         bcnt
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    // Push serves the highest pending register first, pull the lowest.
    function automatic logic [IW-1:0] pick(input logic [NREG-1:0] m, input logic d);
        pick = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (d) begin
                if (m[int'(NREG) - 1 - i]) pick = IW'(int'(NREG) - 1 - i);
            end else begin
                if (m[i]) pick = IW'(i);
            end
        end
    endfunction

    function automatic logic [15:0] word_of(input logic [IW-1:0] idx,
                                            input logic [NREG*16-1:0] din);
        word_of = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (IW'(i) == idx) word_of = din[16*i +: 16];
        end
    endfunction

    logic [1:0]      state, state_nxt;
    logic [NREG-1:0] pend, pend_nxt;
    logic [AW-1:0]   sp_cur, sp_nxt;
    logic            second, second_nxt;
    logic            dir_q, dir_nxt;
    logic [4:0]      bcnt_nxt;
    logic            busy_nxt, done_nxt, sp_we_nxt;
    logic [AW-1:0]   sp_out_nxt, mem_addr_nxt;
    logic [7:0]      mem_dout_nxt, wr_data_nxt;
    logic            mem_we_nxt, mem_rd_nxt;
    logic            wr_en_nxt, wr_hi_nxt;
    logic [NREG-1:0] wr_sel_nxt;
    logic            load;
    logic [IW-1:0]   cidx, nidx;
    logic            cwide, chi, clast, nwide, nhi;
    logic [15:0]     nword;

    // Byte currently on the bus: 16-bit pushes go low then high, pulls high then low.
    assign cidx  = pick(pend, dir_q);
    assign cwide = WIDE[cidx];
    assign chi   = cwide & (dir_q ? ~second : second);
    assign clast = ~cwide | second;

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        sp_nxt       = sp_cur;
        second_nxt   = second;
        dir_nxt      = dir_q;
        bcnt_nxt     = bcnt;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        sp_we_nxt    = 1'b0;
        sp_out_nxt   = sp_out;
        mem_addr_nxt = mem_addr;
        mem_dout_nxt = mem_dout;
        mem_we_nxt   = mem_we;
        mem_rd_nxt   = mem_rd;
        wr_en_nxt    = 1'b0;
        wr_sel_nxt   = wr_sel;
        wr_hi_nxt    = wr_hi;
        wr_data_nxt  = wr_data;
        load         = 1'b0;
        nidx         = '0;
        nwide        = 1'b0;
        nhi          = 1'b0;
        nword        = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    dir_nxt    = dir;
                    pend_nxt   = mask;
                    sp_nxt     = sp_in;
                    second_nxt = 1'b0;
                    bcnt_nxt   = '0;
                    busy_nxt   = 1'b1;
                    if (mask == '0) begin
                        state_nxt  = FIN;
                        done_nxt   = 1'b1;
                        sp_we_nxt  = 1'b1;
                        sp_out_nxt = sp_in;
                    end else begin
                        state_nxt  = XFER;
                        mem_we_nxt = ~dir;
                        mem_rd_nxt = dir;
                        load       = 1'b1;
                    end
                end
            end
            XFER: begin
                if (mem_ok && (mem_we || mem_rd)) begin
                    bcnt_nxt = bcnt + 5'd1;
                    sp_nxt   = dir_q ? sp_cur + AW'(1) : sp_cur - AW'(1);
                    if (dir_q) begin
                        wr_en_nxt   = 1'b1;
                        wr_sel_nxt  = NREG'(1) << cidx;
                        wr_hi_nxt   = chi;
                        wr_data_nxt = mem_din;
                    end
                    if (clast) begin
                        pend_nxt[cidx] = 1'b0;
                        second_nxt     = 1'b0;
                    end else begin
                        second_nxt = 1'b1;
                    end
                    if (pend_nxt == '0) begin
                        state_nxt  = FIN;
                        done_nxt   = 1'b1;
                        sp_we_nxt  = 1'b1;
                        sp_out_nxt = sp_nxt;
                        mem_we_nxt = 1'b0;
                        mem_rd_nxt = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase

        // Present the next byte's address and data one cycle ahead.
        if (load) begin
            nidx         = pick(pend_nxt, dir_nxt);
            nwide        = WIDE[nidx];
            nhi          = nwide & (dir_nxt ? ~second_nxt : second_nxt);
            nword        = word_of(nidx, reg_din);
            mem_addr_nxt = dir_nxt ? sp_nxt : sp_nxt - AW'(1);
            mem_dout_nxt = dir_nxt ? 8'h00 : (nhi ? nword[15:8] : nword[7:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= '0;
            sp_cur   <= '0;
            second   <= 1'b0;
            dir_q    <= 1'b0;
            bcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sp_we    <= 1'b0;
            sp_out   <= '0;
            mem_addr <= '0;
            mem_dout <= '0;
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
            wr_en    <= 1'b0;
            wr_sel   <= '0;
            wr_hi    <= 1'b0;
            wr_data  <= '0;
        end else if (cen) begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            sp_cur   <= sp_nxt;
            second   <= second_nxt;
            dir_q    <= dir_nxt;
            bcnt     <= bcnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            sp_we    <= sp_we_nxt;
            sp_out   <= sp_out_nxt;
            mem_addr <= mem_addr_nxt;
            mem_dout <= mem_dout_nxt;
            mem_we   <= mem_we_nxt;
            mem_rd   <= mem_rd_nxt;
            wr_en    <= wr_en_nxt;
            wr_sel   <= wr_sel_nxt;
            wr_hi    <= wr_hi_nxt;
            wr_data  <= wr_data_nxt;
        end
    end

endmodule
